// File: rtl/scpu_pkg.sv
// Shared SCPU constants, the issuer FSM state type and the result-checksum helper.
package scpu_pkg;

  localparam int unsigned INSTR_W  = 19;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Wrapping 16-bit sum of the result registers; out0 sits in the low word.
  function automatic logic [DATA_W-1:0] reg_sum(input logic [NUM_REGS*DATA_W-1:0] flat);
    logic [DATA_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      acc = acc + flat[i*DATA_W +: DATA_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/scpu_instr_fifo.sv
// Synchronous instruction FIFO, no bypass: a pushed word is visible at head the next cycle.
module scpu_instr_fifo
  import scpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == (PTR_W+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/scpu_instr_issuer.sv
// Host-side SCPU driver: queues instructions, issues one at a time when the CPU is idle,
// captures the result registers on out_valid and tracks counts and a sticky timeout.
module scpu_instr_issuer
  import scpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  input  logic [INSTR_W-1:0]           push_data,
  output logic                         push_ready,
  output logic                         in_valid,
  output logic [INSTR_W-1:0]           instruction,
  input  logic                         busy,
  input  logic                         out_valid,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  input  logic [3:0]                   rd_sel,
  output logic [DATA_W-1:0]            rd_data,
  output logic [DATA_W-1:0]            checksum,
  output logic [CNT_W-1:0]             issued_cnt,
  output logic [CNT_W-1:0]             done_cnt,
  output logic                         idle,
  output logic                         err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic                 r_in_valid;
  logic [INSTR_W-1:0]   r_instr;
  logic [DATA_W-1:0]    r_snap [NUM_REGS];
  logic [DATA_W-1:0]    r_checksum;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_done;
  logic                 r_err;
  logic [TMO_W-1:0]     r_tmo;

  logic                 w_full;
  logic                 w_empty;
  logic [INSTR_W-1:0]   w_head;
  logic                 w_push;
  logic                 w_pop;

  assign push_ready = !w_full;
  assign w_push     = push_valid && push_ready;
  // The head is popped on the same edge that launches ISSUE, so in_valid carries it as a register.
  assign w_pop      = (r_state == IDLE) && !w_empty && !busy;

  scpu_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_valid <= 1'b0;
      r_instr    <= '0;
      r_checksum <= '0;
      r_issued   <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_in_valid <= 1'b0;
      r_instr    <= '0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state    <= ISSUE;
            r_in_valid <= 1'b1;
            r_instr    <= w_head;
            r_issued   <= r_issued + 1'b1;
            r_tmo      <= '0;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (out_valid) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              r_snap[i] <= regs_flat[i*DATA_W +: DATA_W];
            end
            r_checksum <= reg_sum(regs_flat);
            r_done     <= r_done + 1'b1;
            r_state    <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_valid    = r_in_valid;
  assign instruction = r_instr;
  assign rd_data     = r_snap[rd_sel];
  assign checksum    = r_checksum;
  assign issued_cnt  = r_issued;
  assign done_cnt    = r_done;
  assign err_timeout = r_err;
  assign idle        = w_empty && (r_state == IDLE);

endmodule
